issue_queue_n: RTL and testbench
================================

ISSUE_QUEUE_N -- requirements
Module: issue_queue_n

Interface
REQ-001 Parameter DEPTH, default 16, number of queue entries (power of two, 4..64).
REQ-002 Parameter TAG_W, default 6, physical-register tag width; tag 0 means "no source".
REQ-003 Parameter DATA_W, default 32, operand width.
REQ-004 Parameter PAY_W, default 137, opaque decoded-instruction payload width.
REQ-005 Parameter NUM_BC, default 2, number of result-broadcast ports.
REQ-006 Parameter AGE_W, default 8, instruction-number width used for age ordering.
REQ-007 Ports SHALL be: CLK in 1 clock; RESET in 1 asynchronous active-low reset; STALL in 1 freeze; FLUSH in 1 synchronous clear.
REQ-008 Enqueue ports SHALL be: enq_valid in 1; enq_ready out 1; enq_payload in PAY_W; enq_tag_a, enq_tag_b in TAG_W; enq_rdy_a, enq_rdy_b in 1 (source value present); enq_val_a, enq_val_b in DATA_W; enq_age in AGE_W.
REQ-009 Broadcast ports SHALL be: bc_valid in NUM_BC; bc_tag in NUM_BC*TAG_W; bc_val in NUM_BC*DATA_W (port p at slice p).
REQ-010 Issue ports SHALL be: iss_valid out 1; iss_ready in 1; iss_payload out PAY_W; iss_op_a, iss_op_b out DATA_W; iss_age out AGE_W.
REQ-011 Status port SHALL be: count out clog2(DEPTH)+1, number of occupied entries.

Function
REQ-012 enq_ready SHALL equal (count < DEPTH) && !FLUSH && !STALL; slots freed by an issue on the same edge are not reused until the next cycle.
REQ-013 On enq_valid && enq_ready, the entry SHALL be written at the lowest-index free slot at the rising edge.
REQ-014 A source SHALL be marked ready at enqueue if its tag is 0, its enq_rdy is 1, or any valid broadcast in the same cycle matches its tag (broadcast value captured, bypass).
REQ-015 Each cycle, every occupied not-ready source whose tag matches a valid, nonzero bc_tag SHALL capture bc_val and become ready at the edge; if several ports match, the lowest port index wins.
REQ-016 Broadcast capture SHALL occur even while STALL is high.
REQ-017 An entry is eligible when occupied with both sources ready; selection SHALL pick the oldest eligible entry, where a is older than b iff bit AGE_W-1 of (a - b) mod 2^AGE_W is 1.
REQ-018 The issue register SHALL load the selected entry (freeing its slot) at an edge when !STALL && (!iss_valid || iss_ready) and an eligible entry exists; iss_valid then is 1.
REQ-019 When iss_valid && iss_ready and no entry is eligible (or STALL), iss_valid SHALL fall to 0 at the edge; outputs otherwise hold stable while iss_valid && !iss_ready.
REQ-020 Minimum latency: entry enqueued ready at edge N SHALL appear on iss_* after edge N+1; an entry woken by broadcast in cycle N SHALL be selectable in cycle N+1.
REQ-021 STALL high SHALL block enqueue, selection and issue-register updates; count unchanged except by FLUSH.
REQ-022 FLUSH high at an edge SHALL clear all entries, iss_valid and count to 0, overriding STALL, enqueue and issue.
REQ-023 count SHALL be updated as count + enq - issue-load each edge, never exceeding DEPTH.

Reset
REQ-024 RESET low SHALL immediately clear all valid/ready bits, count, iss_valid, iss_payload, iss_op_a, iss_op_b, iss_age to 0; enq_ready is 1 after release (FLUSH, STALL low).

Verification
REQ-025 Enqueue ages 5,3,7 all ready, iss_ready=1 -> issue order 3,5,7 on consecutive cycles, count 3->0.
REQ-026 Enqueue tag_a=12 not ready; cycle later bc_valid[1]=1, bc_tag=12, bc_val=0xDEADBEEF -> next cycle iss_op_a=0xDEADBEEF.
REQ-027 Same-cycle enqueue tag_b=9 with broadcast tag 9 val 0x55 -> entry issues with iss_op_b=0x55, no hang.
REQ-028 Fill DEPTH entries -> enq_ready=0, count=DEPTH; one issue -> enq_ready=1 the following cycle.
REQ-029 AGE_W=8 wrap: ages 254,255,0,1 ready -> issue order 254,255,0,1.
REQ-030 iss_ready=0 with pending entries, then FLUSH -> iss_valid=0, count=0 next cycle; RESET low mid-operation -> all outputs 0 immediately.

Source files
------------

// File: rtl/issue_queue_n.sv
// Out-of-order issue queue: holds decoded instructions until both
// source operands are present, then issues the oldest ready one.
//
// Ports:
//   CLK, RESET (async, active low), STALL (freeze), FLUSH (sync clear)
//   enq_*  : one instruction per cycle in, with source tags/values
//   bc_*   : NUM_BC result broadcast ports (tag + value per port)
//   iss_*  : valid/ready issue register with payload and operands
//   count  : number of occupied queue entries
module issue_queue_n #(
    parameter int DEPTH  = 16,
    parameter int TAG_W  = 6,
    parameter int DATA_W = 32,
    parameter int PAY_W  = 137,
    parameter int NUM_BC = 2,
    parameter int AGE_W  = 8
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic                     STALL,
    input  logic                     FLUSH,
    input  logic                     enq_valid,
    output logic                     enq_ready,
    input  logic [PAY_W-1:0]         enq_payload,
    input  logic [TAG_W-1:0]         enq_tag_a,
    input  logic [TAG_W-1:0]         enq_tag_b,
    input  logic                     enq_rdy_a,
    input  logic                     enq_rdy_b,
    input  logic [DATA_W-1:0]        enq_val_a,
    input  logic [DATA_W-1:0]        enq_val_b,
    input  logic [AGE_W-1:0]         enq_age,
    input  logic [NUM_BC-1:0]        bc_valid,
    input  logic [NUM_BC*TAG_W-1:0]  bc_tag,
    input  logic [NUM_BC*DATA_W-1:0] bc_val,
    output logic                     iss_valid,
    input  logic                     iss_ready,
    output logic [PAY_W-1:0]         iss_payload,
    output logic [DATA_W-1:0]        iss_op_a,
    output logic [DATA_W-1:0]        iss_op_b,
    output logic [AGE_W-1:0]         iss_age,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int IW = $clog2(DEPTH);
    localparam int CW = IW + 1;

    logic [DEPTH-1:0]  valid_q, valid_d;
    logic [DEPTH-1:0]  rdy_a_q, rdy_a_d;
    logic [DEPTH-1:0]  rdy_b_q, rdy_b_d;
    logic [TAG_W-1:0]  tag_a_q [DEPTH];
    logic [TAG_W-1:0]  tag_a_d [DEPTH];
    logic [TAG_W-1:0]  tag_b_q [DEPTH];
    logic [TAG_W-1:0]  tag_b_d [DEPTH];
    logic [DATA_W-1:0] val_a_q [DEPTH];
    logic [DATA_W-1:0] val_a_d [DEPTH];
    logic [DATA_W-1:0] val_b_q [DEPTH];
    logic [DATA_W-1:0] val_b_d [DEPTH];
    logic [PAY_W-1:0]  pay_q   [DEPTH];
    logic [PAY_W-1:0]  pay_d   [DEPTH];
    logic [AGE_W-1:0]  age_q   [DEPTH];
    logic [AGE_W-1:0]  age_d   [DEPTH];

    logic [CW-1:0]     count_q, count_d;
    logic              iss_valid_q, iss_valid_d;
    logic [PAY_W-1:0]  iss_pay_q, iss_pay_d;
    logic [DATA_W-1:0] iss_a_q, iss_a_d;
    logic [DATA_W-1:0] iss_b_q, iss_b_d;
    logic [AGE_W-1:0]  iss_age_q, iss_age_d;

    logic              free_found;
    logic [IW-1:0]     free_idx;
    logic [DEPTH-1:0]  elig;
    logic              sel_found;
    logic [IW-1:0]     sel_idx;
    logic              load;
    logic              enq_fire;
    logic [DATA_W:0]   byp_a, byp_b;
    logic [DATA_W:0]   wk_a, wk_b;

    // Wrap-aware age compare: a is older than b when (a-b) is "negative".
    function automatic logic older(input logic [AGE_W-1:0] a,
                                   input logic [AGE_W-1:0] b);
        logic [AGE_W-1:0] d;
        d = a - b;
        return d[AGE_W-1];
    endfunction

    // Returns {hit, value}; the downward loop lets the lowest port win.
    function automatic logic [DATA_W:0] bc_lookup(input logic [TAG_W-1:0] t);
        logic [DATA_W:0] r;
        r = '0;
        if (t != '0) begin
            for (int p = NUM_BC - 1; p >= 0; p--) begin
                if (bc_valid[p] && bc_tag[p*TAG_W +: TAG_W] == t) begin
                    r = {1'b1, bc_val[p*DATA_W +: DATA_W]};
                end
            end
        end
        return r;
    endfunction

    assign enq_ready   = (count_q < CW'(DEPTH)) && !FLUSH && !STALL;
    assign enq_fire    = enq_valid && enq_ready && free_found;
    assign iss_valid   = iss_valid_q;
    assign iss_payload = iss_pay_q;
    assign iss_op_a    = iss_a_q;
    assign iss_op_b    = iss_b_q;
    assign iss_age     = iss_age_q;
    assign count       = count_q;

    always_comb begin : find_free
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!valid_q[i]) begin
                free_found = 1'b1;
                free_idx   = IW'(i);
            end
        end
    end

    always_comb begin : pick_oldest
        elig      = valid_q & rdy_a_q & rdy_b_q;
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (elig[i] && (!sel_found || older(age_q[i], age_q[sel_idx]))) begin
                sel_found = 1'b1;
                sel_idx   = IW'(i);
            end
        end
    end

    assign load = !STALL && !FLUSH && (!iss_valid_q || iss_ready) && sel_found;

    always_comb begin : entry_next
        valid_d = valid_q;
        rdy_a_d = rdy_a_q;
        rdy_b_d = rdy_b_q;
        tag_a_d = tag_a_q;
        tag_b_d = tag_b_q;
        val_a_d = val_a_q;
        val_b_d = val_b_q;
        pay_d   = pay_q;
        age_d   = age_q;
        wk_a    = '0;
        wk_b    = '0;
        byp_a   = bc_lookup(enq_tag_a);
        byp_b   = bc_lookup(enq_tag_b);

        // Wakeup runs regardless of STALL so no result is missed.
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && !rdy_a_q[i]) begin
                wk_a = bc_lookup(tag_a_q[i]);
                if (wk_a[DATA_W]) begin
                    rdy_a_d[i] = 1'b1;
                    val_a_d[i] = wk_a[DATA_W-1:0];
                end
            end
            if (valid_q[i] && !rdy_b_q[i]) begin
                wk_b = bc_lookup(tag_b_q[i]);
                if (wk_b[DATA_W]) begin
                    rdy_b_d[i] = 1'b1;
                    val_b_d[i] = wk_b[DATA_W-1:0];
                end
            end
        end

        if (load) begin
            valid_d[sel_idx] = 1'b0;
        end

        if (enq_fire) begin
            valid_d[free_idx] = 1'b1;
            tag_a_d[free_idx] = enq_tag_a;
            tag_b_d[free_idx] = enq_tag_b;
            pay_d[free_idx]   = enq_payload;
            age_d[free_idx]   = enq_age;
            rdy_a_d[free_idx] = (enq_tag_a == '0) || enq_rdy_a || byp_a[DATA_W];
            rdy_b_d[free_idx] = (enq_tag_b == '0) || enq_rdy_b || byp_b[DATA_W];
            val_a_d[free_idx] = (!enq_rdy_a && byp_a[DATA_W]) ?
                                byp_a[DATA_W-1:0] : enq_val_a;
            val_b_d[free_idx] = (!enq_rdy_b && byp_b[DATA_W]) ?
                                byp_b[DATA_W-1:0] : enq_val_b;
        end

        if (FLUSH) begin
            valid_d = '0;
            rdy_a_d = '0;
            rdy_b_d = '0;
        end
    end

    always_comb begin : issue_next
        iss_valid_d = iss_valid_q;
        iss_pay_d   = iss_pay_q;
        iss_a_d     = iss_a_q;
        iss_b_d     = iss_b_q;
        iss_age_d   = iss_age_q;
        if (FLUSH) begin
            iss_valid_d = 1'b0;
        end else if (load) begin
            iss_valid_d = 1'b1;
            iss_pay_d   = pay_q[sel_idx];
            iss_a_d     = val_a_q[sel_idx];
            iss_b_d     = val_b_q[sel_idx];
            iss_age_d   = age_q[sel_idx];
        end else if (iss_valid_q && iss_ready) begin
            iss_valid_d = 1'b0;
        end
        count_d = FLUSH ? '0 : count_q + CW'(enq_fire) - CW'(load);
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            valid_q     <= '0;
            rdy_a_q     <= '0;
            rdy_b_q     <= '0;
            count_q     <= '0;
            iss_valid_q <= 1'b0;
            iss_pay_q   <= '0;
            iss_a_q     <= '0;
            iss_b_q     <= '0;
            iss_age_q   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                tag_a_q[i] <= '0;
                tag_b_q[i] <= '0;
                val_a_q[i] <= '0;
                val_b_q[i] <= '0;
                pay_q[i]   <= '0;
                age_q[i]   <= '0;
            end
        end else begin
            valid_q     <= valid_d;
            rdy_a_q     <= rdy_a_d;
            rdy_b_q     <= rdy_b_d;
            count_q     <= count_d;
            iss_valid_q <= iss_valid_d;
            iss_pay_q   <= iss_pay_d;
            iss_a_q     <= iss_a_d;
            iss_b_q     <= iss_b_d;
            iss_age_q   <= iss_age_d;
            tag_a_q     <= tag_a_d;
            tag_b_q     <= tag_b_d;
            val_a_q     <= val_a_d;
            val_b_q     <= val_b_d;
            pay_q       <= pay_d;
            age_q       <= age_d;
        end
    end

endmodule

// File: tb/tb_issue_queue_n.sv
// Scoreboard bench for issue_queue_n: ordering, wakeup, bypass,
// stall, full, age wrap, flush and async reset.
module tb_issue_queue_n;

    localparam int DEPTH  = 16;
    localparam int TAG_W  = 6;
    localparam int DATA_W = 32;
    localparam int PAY_W  = 137;
    localparam int NUM_BC = 2;
    localparam int AGE_W  = 8;

    logic                     CLK, RESET, STALL, FLUSH;
    logic                     enq_valid, enq_ready;
    logic [PAY_W-1:0]         enq_payload;
    logic [TAG_W-1:0]         enq_tag_a, enq_tag_b;
    logic                     enq_rdy_a, enq_rdy_b;
    logic [DATA_W-1:0]        enq_val_a, enq_val_b;
    logic [AGE_W-1:0]         enq_age;
    logic [NUM_BC-1:0]        bc_valid;
    logic [NUM_BC*TAG_W-1:0]  bc_tag;
    logic [NUM_BC*DATA_W-1:0] bc_val;
    logic                     iss_valid, iss_ready;
    logic [PAY_W-1:0]         iss_payload;
    logic [DATA_W-1:0]        iss_op_a, iss_op_b;
    logic [AGE_W-1:0]         iss_age;
    logic [$clog2(DEPTH):0]   count;

    issue_queue_n #(
        .DEPTH(DEPTH), .TAG_W(TAG_W), .DATA_W(DATA_W),
        .PAY_W(PAY_W), .NUM_BC(NUM_BC), .AGE_W(AGE_W)
    ) dut (
        .CLK(CLK), .RESET(RESET), .STALL(STALL), .FLUSH(FLUSH),
        .enq_valid(enq_valid), .enq_ready(enq_ready),
        .enq_payload(enq_payload),
        .enq_tag_a(enq_tag_a), .enq_tag_b(enq_tag_b),
        .enq_rdy_a(enq_rdy_a), .enq_rdy_b(enq_rdy_b),
        .enq_val_a(enq_val_a), .enq_val_b(enq_val_b),
        .enq_age(enq_age),
        .bc_valid(bc_valid), .bc_tag(bc_tag), .bc_val(bc_val),
        .iss_valid(iss_valid), .iss_ready(iss_ready),
        .iss_payload(iss_payload),
        .iss_op_a(iss_op_a), .iss_op_b(iss_op_b),
        .iss_age(iss_age), .count(count)
    );

    typedef struct {
        logic [AGE_W-1:0]  age;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic [PAY_W-1:0]  pay;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [PAY_W-1:0] rnd_pay();
        return PAY_W'({$urandom, $urandom, $urandom, $urandom, $urandom});
    endfunction

    function automatic exp_t mk(input logic [AGE_W-1:0] age,
                                input logic [DATA_W-1:0] a,
                                input logic [DATA_W-1:0] b,
                                input logic [PAY_W-1:0] pay);
        exp_t e;
        e.age = age; e.a = a; e.b = b; e.pay = pay;
        return e;
    endfunction

    task automatic tick();
        @(negedge CLK);
    endtask

    task automatic enq(input logic [AGE_W-1:0] age,
                       input logic [TAG_W-1:0] ta, input logic ra,
                       input logic [DATA_W-1:0] va,
                       input logic [TAG_W-1:0] tb, input logic rb,
                       input logic [DATA_W-1:0] vb,
                       input logic [PAY_W-1:0] pay);
        total++;
        if (enq_ready !== 1'b1) begin
            bad++;
            $display("FAIL enq_ready age=%0d: got %b want 1", age, enq_ready);
        end
        enq_age = age; enq_payload = pay;
        enq_tag_a = ta; enq_rdy_a = ra; enq_val_a = va;
        enq_tag_b = tb; enq_rdy_b = rb; enq_val_b = vb;
        enq_valid = 1'b1;
        tick();
        enq_valid = 1'b0;
    endtask

    task automatic drain(input int n, output int cycles);
        exp_t e;
        int   got;
        got = 0;
        cycles = 0;
        iss_ready = 1'b1;
        while (got < n && cycles < 200) begin
            if (iss_valid === 1'b1) begin
                total++;
                if (sb.size() == 0) begin
                    bad++;
                    $display("FAIL issue unexpected: age=%0d", iss_age);
                end else begin
                    e = sb.pop_front();
                    if (iss_age !== e.age || iss_op_a !== e.a ||
                        iss_op_b !== e.b || iss_payload !== e.pay) begin
                        bad++;
                        $display("FAIL issue: got age=%0d a=%h b=%h want age=%0d a=%h b=%h pay_ok=%b",
                                 iss_age, iss_op_a, iss_op_b, e.age, e.a, e.b,
                                 iss_payload === e.pay);
                    end
                end
                got++;
            end
            tick();
            cycles++;
        end
        total++;
        if (got != n) begin
            bad++;
            $display("FAIL drain timeout: got %0d issues want %0d", got, n);
        end
    endtask

    task automatic test_reset();
        RESET = 1'b1;
        #2 RESET = 1'b0;
        #1;
        total++;
        if (count !== 0 || iss_valid !== 1'b0 || iss_payload !== '0 ||
            iss_op_a !== 0 || iss_op_b !== 0 || iss_age !== 0) begin
            bad++;
            $display("FAIL reset: count=%0d iss_valid=%b age=%0d a=%h b=%h, want all 0",
                     count, iss_valid, iss_age, iss_op_a, iss_op_b);
        end
        tick();
        RESET = 1'b1;
        #1;
        total++;
        if (enq_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset enq_ready: got %b want 1", enq_ready);
        end
    endtask

    task automatic test_age_order();
        logic [PAY_W-1:0] p [4];
        int cyc;
        for (int i = 0; i < 4; i++) p[i] = rnd_pay();
        iss_ready = 1'b0;
        enq(8'd2, 0, 1'b1, 32'h02, 0, 1'b1, 32'h20, p[0]);
        enq(8'd5, 0, 1'b1, 32'h05, 0, 1'b1, 32'h50, p[1]);
        enq(8'd3, 0, 1'b1, 32'h03, 0, 1'b1, 32'h30, p[2]);
        enq(8'd7, 0, 1'b1, 32'h07, 0, 1'b1, 32'h70, p[3]);
        sb.push_back(mk(8'd2, 32'h02, 32'h20, p[0]));
        sb.push_back(mk(8'd3, 32'h03, 32'h30, p[2]));
        sb.push_back(mk(8'd5, 32'h05, 32'h50, p[1]));
        sb.push_back(mk(8'd7, 32'h07, 32'h70, p[3]));
        total++;
        if (count !== 3 || iss_valid !== 1'b1 || iss_age !== 8'd2) begin
            bad++;
            $display("FAIL age_order setup: count=%0d valid=%b age=%0d want 3 1 2",
                     count, iss_valid, iss_age);
        end
        drain(4, cyc);
        total++;
        if (cyc != 4) begin
            bad++;
            $display("FAIL age_order back_to_back: cycles=%0d want 4", cyc);
        end
        total++;
        if (count !== 0 || iss_valid !== 1'b0) begin
            bad++;
            $display("FAIL age_order end: count=%0d valid=%b want 0 0", count, iss_valid);
        end
    endtask

    task automatic test_wakeup();
        iss_ready = 1'b1;
        enq(8'd10, 6'd12, 1'b0, 32'h0, 6'd0, 1'b0, 32'h11, rnd_pay());
        bc_valid = 2'b10;
        bc_tag   = {6'd12, 6'd13};
        bc_val   = {32'hDEADBEEF, 32'h0BADF00D};
        total++;
        if (iss_valid !== 1'b0) begin
            bad++;
            $display("FAIL wakeup early: iss_valid=%b want 0", iss_valid);
        end
        tick();
        bc_valid = '0;
        total++;
        if (iss_valid !== 1'b0) begin
            bad++;
            $display("FAIL wakeup select: iss_valid=%b want 0", iss_valid);
        end
        tick();
        total++;
        if (iss_valid !== 1'b1 || iss_op_a !== 32'hDEADBEEF ||
            iss_op_b !== 32'h11 || iss_age !== 8'd10) begin
            bad++;
            $display("FAIL wakeup issue: valid=%b a=%h b=%h age=%0d want 1 deadbeef 11 10",
                     iss_valid, iss_op_a, iss_op_b, iss_age);
        end
        tick();
        total++;
        if (iss_valid !== 1'b0 || count !== 0) begin
            bad++;
            $display("FAIL wakeup end: valid=%b count=%0d want 0 0", iss_valid, count);
        end
    endtask

    task automatic test_bypass();
        logic [PAY_W-1:0] p;
        int cyc;
        p = rnd_pay();
        bc_valid = 2'b11;
        bc_tag   = {6'd9, 6'd9};
        bc_val   = {32'h66, 32'h55};
        enq(8'd20, 6'd0, 1'b0, 32'h1234, 6'd9, 1'b0, 32'h0, p);
        bc_valid = '0;
        sb.push_back(mk(8'd20, 32'h1234, 32'h55, p));
        drain(1, cyc);
        total++;
        if (count !== 0) begin
            bad++;
            $display("FAIL bypass count: got %0d want 0", count);
        end
    endtask

    task automatic test_stall();
        logic [PAY_W-1:0] p0, p1;
        int cyc;
        p0 = rnd_pay();
        p1 = rnd_pay();
        iss_ready = 1'b1;
        enq(8'd60, 6'd7, 1'b0, 32'h0, 6'd0, 1'b0, 32'h06, p0);
        enq(8'd61, 6'd0, 1'b0, 32'h61, 6'd0, 1'b0, 32'h62, p1);
        STALL    = 1'b1;
        bc_valid = 2'b10;
        bc_tag   = {6'd7, 6'd7};
        bc_val   = {32'h77, 32'hBAD};
        #1;
        total++;
        if (enq_ready !== 1'b0) begin
            bad++;
            $display("FAIL stall enq_ready: got %b want 0", enq_ready);
        end
        tick();
        bc_valid = '0;
        for (int k = 0; k < 2; k++) begin
            total++;
            if (iss_valid !== 1'b0 || count !== 2) begin
                bad++;
                $display("FAIL stall hold %0d: valid=%b count=%0d want 0 2",
                         k, iss_valid, count);
            end
            if (k == 0) tick();
        end
        STALL = 1'b0;
        sb.push_back(mk(8'd60, 32'h77, 32'h06, p0));
        sb.push_back(mk(8'd61, 32'h61, 32'h62, p1));
        drain(2, cyc);
        total++;
        if (count !== 0) begin
            bad++;
            $display("FAIL stall end count: got %0d want 0", count);
        end
    endtask

    task automatic test_full();
        logic [PAY_W-1:0] p [DEPTH];
        int off, cyc;
        iss_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            off = (i * 5) % DEPTH;
            p[off] = rnd_pay();
            enq(AGE_W'(40 + off), 6'd30, 1'b0, 32'h0, 6'd0, 1'b0,
                DATA_W'(off), p[off]);
        end
        for (int k = 0; k < DEPTH; k++)
            sb.push_back(mk(AGE_W'(40 + k), 32'hA5A50030, DATA_W'(k), p[k]));
        total++;
        if (count !== DEPTH || enq_ready !== 1'b0) begin
            bad++;
            $display("FAIL full: count=%0d enq_ready=%b want %0d 0",
                     count, enq_ready, DEPTH);
        end
        enq_age = 8'd99; enq_tag_a = 0; enq_tag_b = 0;
        enq_valid = 1'b1;
        tick();
        enq_valid = 1'b0;
        total++;
        if (count !== DEPTH) begin
            bad++;
            $display("FAIL full drop: count=%0d want %0d", count, DEPTH);
        end
        iss_ready = 1'b1;
        bc_valid = 2'b01;
        bc_tag   = {6'd0, 6'd30};
        bc_val   = {32'h0, 32'hA5A50030};
        tick();
        bc_valid = '0;
        total++;
        if (count !== DEPTH || enq_ready !== 1'b0) begin
            bad++;
            $display("FAIL full wake: count=%0d enq_ready=%b want %0d 0",
                     count, enq_ready, DEPTH);
        end
        tick();
        total++;
        if (count !== DEPTH - 1 || enq_ready !== 1'b1) begin
            bad++;
            $display("FAIL full free: count=%0d enq_ready=%b want %0d 1",
                     count, enq_ready, DEPTH - 1);
        end
        drain(DEPTH, cyc);
        total++;
        if (count !== 0) begin
            bad++;
            $display("FAIL full end count: got %0d want 0", count);
        end
    endtask

    task automatic test_wrap();
        logic [AGE_W-1:0] ages [5];
        logic [AGE_W-1:0] order [5];
        logic [PAY_W-1:0] p [5];
        int cyc;
        ages  = '{8'd250, 8'd0, 8'd255, 8'd1, 8'd254};
        order = '{8'd250, 8'd254, 8'd255, 8'd0, 8'd1};
        iss_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            p[i] = rnd_pay();
            enq(ages[i], 0, 1'b1, DATA_W'(ages[i]), 0, 1'b1,
                ~DATA_W'(ages[i]), p[i]);
        end
        for (int k = 0; k < 5; k++)
            for (int i = 0; i < 5; i++)
                if (ages[i] == order[k])
                    sb.push_back(mk(ages[i], DATA_W'(ages[i]),
                                    ~DATA_W'(ages[i]), p[i]));
        drain(5, cyc);
        total++;
        if (cyc != 5 || count !== 0) begin
            bad++;
            $display("FAIL wrap end: cycles=%0d count=%0d want 5 0", cyc, count);
        end
    endtask

    task automatic test_flush();
        iss_ready = 1'b0;
        enq(8'd70, 0, 1'b1, 32'h70, 0, 1'b1, 32'h0, rnd_pay());
        enq(8'd71, 0, 1'b1, 32'h71, 0, 1'b1, 32'h0, rnd_pay());
        enq(8'd72, 0, 1'b1, 32'h72, 0, 1'b1, 32'h0, rnd_pay());
        total++;
        if (iss_valid !== 1'b1 || count !== 2) begin
            bad++;
            $display("FAIL flush setup: valid=%b count=%0d want 1 2", iss_valid, count);
        end
        FLUSH = 1'b1;
        #1;
        total++;
        if (enq_ready !== 1'b0) begin
            bad++;
            $display("FAIL flush enq_ready: got %b want 0", enq_ready);
        end
        tick();
        FLUSH = 1'b0;
        total++;
        if (iss_valid !== 1'b0 || count !== 0) begin
            bad++;
            $display("FAIL flush: valid=%b count=%0d want 0 0", iss_valid, count);
        end
        iss_ready = 1'b1;
        tick();
        tick();
        total++;
        if (iss_valid !== 1'b0 || count !== 0) begin
            bad++;
            $display("FAIL flush ghost: valid=%b count=%0d want 0 0", iss_valid, count);
        end
    endtask

    task automatic test_async_reset();
        logic [PAY_W-1:0] p;
        int cyc;
        iss_ready = 1'b0;
        enq(8'd80, 0, 1'b1, 32'hCAFE0080, 0, 1'b1, 32'hBEEF0080, rnd_pay());
        enq(8'd81, 6'd5, 1'b0, 32'h0, 0, 1'b1, 32'h1, rnd_pay());
        enq(8'd82, 0, 1'b1, 32'h82, 0, 1'b1, 32'h2, rnd_pay());
        total++;
        if (iss_valid !== 1'b1 || iss_op_a !== 32'hCAFE0080) begin
            bad++;
            $display("FAIL areset setup: valid=%b a=%h want 1 cafe0080",
                     iss_valid, iss_op_a);
        end
        #2 RESET = 1'b0;
        #1;
        total++;
        if (count !== 0 || iss_valid !== 1'b0 || iss_payload !== '0 ||
            iss_op_a !== 0 || iss_op_b !== 0 || iss_age !== 0) begin
            bad++;
            $display("FAIL areset: count=%0d valid=%b age=%0d a=%h b=%h want all 0",
                     count, iss_valid, iss_age, iss_op_a, iss_op_b);
        end
        tick();
        RESET = 1'b1;
        #1;
        total++;
        if (enq_ready !== 1'b1 || count !== 0) begin
            bad++;
            $display("FAIL areset release: enq_ready=%b count=%0d want 1 0",
                     enq_ready, count);
        end
        p = rnd_pay();
        enq(8'd90, 0, 1'b1, 32'h90, 0, 1'b1, 32'h91, p);
        sb.push_back(mk(8'd90, 32'h90, 32'h91, p));
        drain(1, cyc);
    endtask

    initial begin
        STALL = 1'b0; FLUSH = 1'b0; enq_valid = 1'b0;
        enq_payload = '0; enq_tag_a = '0; enq_tag_b = '0;
        enq_rdy_a = 1'b0; enq_rdy_b = 1'b0;
        enq_val_a = '0; enq_val_b = '0; enq_age = '0;
        bc_valid = '0; bc_tag = '0; bc_val = '0;
        iss_ready = 1'b0;
        test_reset();
        test_age_order();
        test_wakeup();
        test_bypass();
        test_stall();
        test_full();
        test_wrap();
        test_flush();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
